// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_W_C  = 5;
  localparam int WORD_W_C = 32;
  localparam int CNT_W_C  = 16;

  typedef logic [REG_W_C-1:0]  regbits_t;
  typedef logic [WORD_W_C-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } aluop_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1
  } stage_state_t;

  // Everything latched between decode and execute
  typedef struct packed {
    logic     valid;
    regbits_t rs;
    regbits_t rt;
    regbits_t rd;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    word_t    pc4;
    aluop_t   aluop;
    logic     RegDst;
    logic     ALUSrc;
    logic     RegWr;
    logic     MemRead;
    logic     MemWr;
    logic     MemToReg;
    logic     halt;
  } id_ex_t;

  // Bubble: no side effects, and register index 0 never matches a forward
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Flags a decode instruction that reads the destination of a load
//            still sitting in EX (its data is not available until MEM).
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_W_C
) (
  input  logic             ex_valid,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load into it never creates a hazard
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt & (ex_rt == id_rt);
    load_use = ex_valid & ex_MemRead & (ex_rt != '0) & (rs_match | rt_match) & id_valid;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble insertion, memory
//            freeze, halt state machine and a saturating hold counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int REG_W  = REG_W_C,
  parameter int WORD_W = WORD_W_C,
  parameter int CNT_W  = CNT_W_C
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              mem_req,
  input  logic              dhit,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [WORD_W-1:0] id_pc4,
  input  logic [3:0]        id_aluop,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_RegWr,
  input  logic              id_MemRead,
  input  logic              id_MemWr,
  input  logic              id_MemToReg,
  input  logic              id_halt,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [WORD_W-1:0] ex_rdat1,
  output logic [WORD_W-1:0] ex_rdat2,
  output logic [WORD_W-1:0] ex_imm,
  output logic [WORD_W-1:0] ex_pc4,
  output logic [3:0]        ex_aluop,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_RegWr,
  output logic              ex_MemRead,
  output logic              ex_MemWr,
  output logic              ex_MemToReg,
  output logic              ex_halt,
  output logic              id_hold,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  id_ex_t       pipe_q, pipe_d;
  stage_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         mem_wait;
  logic         load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_valid   (pipe_q.valid),
    .ex_MemRead (pipe_q.MemRead),
    .ex_rt      (pipe_q.rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // Hold request to IF/ID; forced low while reset is asserted
  always_comb begin
    mem_wait = mem_req & ~dhit;
    id_hold  = ~RST & (mem_wait | (load_use & ~flush) | (state_q == HALTED));
  end

  // Next-state and next pipeline contents, first matching condition wins
  always_comb begin
    pipe_d  = pipe_q;
    state_d = state_q;
    if (mem_wait) begin
      // Whole stage frozen; a pending flush is re-presented after the freeze
      pipe_d  = pipe_q;
    end else if (flush) begin
      pipe_d  = ID_EX_BUBBLE;
      state_d = RUN;
    end else if (state_q == HALTED) begin
      pipe_d      = ID_EX_BUBBLE;
      pipe_d.halt = 1'b1;
    end else if (load_use) begin
      pipe_d = ID_EX_BUBBLE;
    end else if (~ihit | ~id_valid) begin
      pipe_d = ID_EX_BUBBLE;
    end else begin
      pipe_d.valid    = 1'b1;
      pipe_d.rs       = id_rs;
      pipe_d.rt       = id_rt;
      pipe_d.rd       = id_rd;
      pipe_d.rdat1    = id_rdat1;
      pipe_d.rdat2    = id_rdat2;
      pipe_d.imm      = id_imm;
      pipe_d.pc4      = id_pc4;
      pipe_d.aluop    = aluop_t'(id_aluop);
      pipe_d.RegDst   = id_RegDst;
      pipe_d.ALUSrc   = id_ALUSrc;
      pipe_d.RegWr    = id_RegWr;
      pipe_d.MemRead  = id_MemRead;
      pipe_d.MemWr    = id_MemWr;
      pipe_d.MemToReg = id_MemToReg;
      pipe_d.halt     = id_halt;
      if (id_halt) begin
        state_d = HALTED;
      end
    end
  end

  // Hold-cycle counter: only counts holds taken while running, saturates
  always_comb begin
    cnt_d = cnt_q;
    if (id_hold && (state_q == RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register, pipeline register and counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pipe_q  <= ID_EX_BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    ex_valid    = pipe_q.valid;
    ex_rs       = pipe_q.rs;
    ex_rt       = pipe_q.rt;
    ex_rd       = pipe_q.rd;
    ex_rdat1    = pipe_q.rdat1;
    ex_rdat2    = pipe_q.rdat2;
    ex_imm      = pipe_q.imm;
    ex_pc4      = pipe_q.pc4;
    ex_aluop    = pipe_q.aluop;
    ex_RegDst   = pipe_q.RegDst;
    ex_ALUSrc   = pipe_q.ALUSrc;
    ex_RegWr    = pipe_q.RegWr;
    ex_MemRead  = pipe_q.MemRead;
    ex_MemWr    = pipe_q.MemWr;
    ex_MemToReg = pipe_q.MemToReg;
    ex_halt     = pipe_q.halt;
    state       = state_q;
    stall_cnt   = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit, mem_req, dhit, flush, id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdat1, id_rdat2, id_imm, id_pc4;
  logic [3:0]  id_aluop;
  logic        id_RegDst, id_ALUSrc, id_RegWr, id_MemRead, id_MemWr, id_MemToReg, id_halt;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdat1, ex_rdat2, ex_imm, ex_pc4;
  logic [3:0]  ex_aluop;
  logic        ex_RegDst, ex_ALUSrc, ex_RegWr, ex_MemRead, ex_MemWr, ex_MemToReg, ex_halt;
  logic        id_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .mem_req(mem_req), .dhit(dhit), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_imm(id_imm), .id_pc4(id_pc4), .id_aluop(id_aluop),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_RegWr(id_RegWr),
    .id_MemRead(id_MemRead), .id_MemWr(id_MemWr), .id_MemToReg(id_MemToReg),
    .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_aluop(ex_aluop), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegWr(ex_RegWr), .ex_MemRead(ex_MemRead), .ex_MemWr(ex_MemWr),
    .ex_MemToReg(ex_MemToReg), .ex_halt(ex_halt),
    .id_hold(id_hold), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit, vld, fl;
    logic [4:0]  rs, rt, rd;
    logic        urt;
    logic [31:0] d1;
    logic        mr;
    logic        e_hold, e_valid;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_d1;
    logic        e_mr;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int ih, input int vl, input int fl, input int rs,
                         input int rt, input int rd, input int urt, input int d1, input int mr,
                         input int h, input int ev, input int ers, input int ert, input int erd,
                         input int ed1, input int emr);
    tv[i].ihit = ih[0];  tv[i].vld = vl[0];  tv[i].fl = fl[0];
    tv[i].rs = rs[4:0];  tv[i].rt = rt[4:0]; tv[i].rd = rd[4:0];
    tv[i].urt = urt[0];  tv[i].d1 = d1;      tv[i].mr = mr[0];
    tv[i].e_hold = h[0]; tv[i].e_valid = ev[0];
    tv[i].e_rs = ers[4:0]; tv[i].e_rt = ert[4:0]; tv[i].e_rd = erd[4:0];
    tv[i].e_d1 = ed1;    tv[i].e_mr = emr[0];
  endtask

  // Present one decode instruction; the other operands follow from rdat1
  task automatic drive(input logic ih, input logic vl, input logic fl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic urt,
                       input logic [31:0] d1, input logic mr, input logic hlt);
    ihit = ih; id_valid = vl; flush = fl;
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_rdat1 = d1; id_rdat2 = ~d1; id_imm = 32'h10; id_pc4 = 32'h400;
    id_aluop = 4'd1; id_RegDst = 1'b1; id_ALUSrc = 1'b0; id_RegWr = 1'b1;
    id_MemRead = mr; id_MemWr = 1'b0; id_MemToReg = mr; id_halt = hlt;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    mem_req = 1'b1;
    dhit    = 1'b0;

    // ih vl fl rs rt rd urt d1 mr | hold | valid rs rt rd d1 mr
    set_vec( 0, 1,1,0, 3, 4, 5,1,32'h1234,0, 0, 1, 3, 4, 5,32'h1234,0);
    set_vec( 1, 1,1,0, 2, 8, 0,0,32'h0100,1, 0, 1, 2, 8, 0,32'h0100,1);
    set_vec( 2, 1,1,0, 8, 9,10,1,32'h2222,0, 1, 0, 0, 0, 0,0,0);
    set_vec( 3, 1,1,0, 8, 9,10,1,32'h2222,0, 0, 1, 8, 9,10,32'h2222,0);
    set_vec( 4, 1,1,0, 1, 0, 0,0,32'h0300,1, 0, 1, 1, 0, 0,32'h0300,1);
    set_vec( 5, 1,1,0, 0, 0,11,1,32'h4444,0, 0, 1, 0, 0,11,32'h4444,0);
    set_vec( 6, 1,1,0, 1, 8, 0,0,32'h0500,1, 0, 1, 1, 8, 0,32'h0500,1);
    set_vec( 7, 1,1,0, 7, 8,12,0,32'h6666,0, 0, 1, 7, 8,12,32'h6666,0);
    set_vec( 8, 1,1,0, 2, 9, 0,0,32'h0700,1, 0, 1, 2, 9, 0,32'h0700,1);
    set_vec( 9, 1,1,0, 9,10, 0,0,32'h0800,1, 1, 0, 0, 0, 0,0,0);
    set_vec(10, 1,1,0, 9,10, 0,0,32'h0800,1, 0, 1, 9,10, 0,32'h0800,1);
    set_vec(11, 1,1,0,10, 3,13,1,32'h0900,0, 1, 0, 0, 0, 0,0,0);
    set_vec(12, 1,1,0,10, 3,13,1,32'h0900,0, 0, 1,10, 3,13,32'h0900,0);
    set_vec(13, 0,1,0, 4, 5, 6,1,32'h0AAA,0, 0, 0, 0, 0, 0,0,0);
    set_vec(14, 1,0,0, 4, 5, 6,1,32'h0AAA,0, 0, 0, 0, 0, 0,0,0);
    set_vec(15, 1,1,1, 6, 7, 8,1,32'h0BBB,0, 0, 0, 0, 0, 0,0,0);
    set_vec(16, 1,1,0, 6, 7, 8,1,32'h0BBB,0, 0, 1, 6, 7, 8,32'h0BBB,0);
    set_vec(17, 1,1,0, 1, 8, 0,0,32'h0C00,1, 0, 1, 1, 8, 0,32'h0C00,1);
    set_vec(18, 1,1,1, 8, 2, 3,1,32'h0D00,0, 0, 0, 0, 0, 0,0,0);
    set_vec(19, 1,1,0, 1, 8, 0,0,32'h0E00,1, 0, 1, 1, 8, 0,32'h0E00,1);
    set_vec(20, 1,1,0, 2, 8, 4,1,32'h0F00,0, 1, 0, 0, 0, 0,0,0);
    set_vec(21, 1,1,0, 2, 8, 4,1,32'h0F00,0, 0, 1, 2, 8, 4,32'h0F00,0);

    // Reset state, with a memory wait pending that must not raise a hold
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_rs", 32'(ex_rs), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_hold", 32'(id_hold), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    mem_req = 1'b0;

    // Table: inputs set at negedge, hold sampled before the edge, ex_* after it
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      drive(tv[i].ihit, tv[i].vld, tv[i].fl, tv[i].rs, tv[i].rt, tv[i].rd,
            tv[i].urt, tv[i].d1, tv[i].mr, 1'b0);
      #1;
      chk($sformatf("v%0d_hold", i), 32'(id_hold), 32'(tv[i].e_hold));
      if (tv[i].e_hold) exp_stall++;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tv[i].e_valid));
      chk($sformatf("v%0d_rs", i), 32'(ex_rs), 32'(tv[i].e_rs));
      chk($sformatf("v%0d_rt", i), 32'(ex_rt), 32'(tv[i].e_rt));
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(tv[i].e_rd));
      chk($sformatf("v%0d_rdat1", i), ex_rdat1, tv[i].e_d1);
      chk($sformatf("v%0d_rdat2", i), ex_rdat2, tv[i].e_valid ? ~tv[i].e_d1 : 32'h0);
      chk($sformatf("v%0d_memrd", i), 32'(ex_MemRead), 32'(tv[i].e_mr));
      chk($sformatf("v%0d_regwr", i), 32'(ex_RegWr), 32'(tv[i].e_valid));
      chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(exp_stall));
    end

    // Memory freeze: EX keeps instruction from the last vector for 3 edges
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      drive(1'b1, 1'b1, (c == 1), 5'd9, 5'd9, 5'd9, 1'b1, 32'h1111, 1'b0, 1'b0);
      mem_req = 1'b1;
      dhit    = 1'b0;
      #1;
      chk("frz_hold", 32'(id_hold), 32'd1);
      exp_stall++;
      @(posedge CLK);
      #1;
      chk("frz_valid", 32'(ex_valid), 32'd1);
      chk("frz_rs", 32'(ex_rs), 32'd2);
      chk("frz_rdat1", ex_rdat1, 32'h0F00);
      chk("frz_stall", 32'(stall_cnt), 32'(exp_stall));
    end
    @(negedge CLK);
    flush = 1'b1;
    dhit  = 1'b1;
    #1;
    chk("frz_end_hold", 32'(id_hold), 32'd0);
    @(posedge CLK);
    #1;
    chk("frz_end_valid", 32'(ex_valid), 32'd0);
    chk("frz_end_rs", 32'(ex_rs), 32'd0);
    chk("frz_end_rdat1", ex_rdat1, 32'h0);
    chk("frz_end_stall", 32'(stall_cnt), 32'(exp_stall));

    // Halt: latch the halt instruction, then ID is ignored until a flush
    @(negedge CLK);
    mem_req = 1'b0;
    dhit    = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 32'h5A5A, 1'b0, 1'b1);
    #1;
    chk("hlt_load_hold", 32'(id_hold), 32'd0);
    @(posedge CLK);
    #1;
    chk("hlt_state", 32'(state), 32'd1);
    chk("hlt_ex_halt", 32'(ex_halt), 32'd1);
    chk("hlt_ex_valid", 32'(ex_valid), 32'd1);
    chk("hlt_ex_rs", 32'(ex_rs), 32'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd7, 5'd8, 1'b1, 32'h7777, 1'b0, 1'b0);
      #1;
      chk("hlt_hold", 32'(id_hold), 32'd1);
      @(posedge CLK);
      #1;
      chk("hlt_keep_halt", 32'(ex_halt), 32'd1);
      chk("hlt_bubble_valid", 32'(ex_valid), 32'd0);
      chk("hlt_bubble_rs", 32'(ex_rs), 32'd0);
      chk("hlt_keep_state", 32'(state), 32'd1);
      chk("hlt_stall", 32'(stall_cnt), 32'(exp_stall));
    end
    @(negedge CLK);
    flush = 1'b1;
    #1;
    chk("hlt_flush_hold", 32'(id_hold), 32'd1);
    @(posedge CLK);
    #1;
    chk("unhlt_state", 32'(state), 32'd0);
    chk("unhlt_ex_halt", 32'(ex_halt), 32'd0);
    chk("unhlt_valid", 32'(ex_valid), 32'd0);
    chk("unhlt_stall", 32'(stall_cnt), 32'(exp_stall));

    // Saturation: load a live instruction, then hold on memory until 0xFFFE
    @(negedge CLK);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1, 32'hBEEF, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    chk("sat_load_rdat1", ex_rdat1, 32'hBEEF);
    @(negedge CLK);
    mem_req = 1'b1;
    dhit    = 1'b0;
    while (exp_stall < 32'hFFFE) begin
      @(posedge CLK);
      exp_stall++;
    end
    #1;
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    end

    // Asynchronous reset between edges while frozen
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_rs", 32'(ex_rs), 32'd0);
    chk("arst_rdat1", ex_rdat1, 32'h0);
    chk("arst_hold", 32'(id_hold), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
